// File: rtl/mem_fill_writer_if.sv
// mem_fill_writer_if
//   Write-port bundle between mem_fill_writer and a memory array.
//
//   Handshake: a write transfers on a rising clk edge where wr_en and
//   wr_ready are both high. While wr_en is high and wr_ready is low,
//   the master holds wr_addr and wr_data stable. wr_en never depends
//   combinationally on wr_ready.
//
//   Signals:
//     wr_en     master -> slave  write request valid
//     wr_ready  slave  -> master memory accepts the write this cycle
//     wr_addr   master -> slave  write address (ADDR_W bits)
//     wr_data   master -> slave  write data byte
interface mem_fill_writer_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/mem_fill_writer.sv
// mem_fill_writer
//   On start, writes DEPTH bytes to addresses 0..DEPTH-1 over the
//   wr_if valid/ready port. Bytes come from an 8-bit LFSR loaded with
//   SEED at every start (a zero SEED is replaced by 8'h01). Accepted
//   bytes are accumulated into a modulo-256 sum and a running maximum,
//   which are published on sum_out/max_out when the last write is
//   accepted and held until the next run completes or reset.
//
//   Optional build macro MEM_FILL_EXT_DATA_EN: bytes are taken from the
//   din/din_valid/din_ready stream instead of the LFSR (the LFSR is not
//   built). A byte is taken only while no write is pending, and the
//   write is presented the following cycle.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      begin a run; sampled only in IDLE
//     busy       high while in FILL
//     done       one-cycle pulse after the last write is accepted
//     dbg_state  current FSM state (0 IDLE, 1 FILL, 2 DONE)
//     sum_out    modulo-256 sum of the bytes of the last completed run
//     max_out    largest byte of the last completed run, zero-extended
//     din*       external byte stream (MEM_FILL_EXT_DATA_EN only)
//     wr_if      memory write port (master side)
module mem_fill_writer #(
  parameter int         DEPTH  = 14,
  parameter int         ADDR_W = 4,
  parameter logic [7:0] SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state,
  output logic [7:0]        sum_out,
  output logic [8:0]        max_out,
`ifdef MEM_FILL_EXT_DATA_EN
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
`endif
  mem_fill_writer_if.master wr_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic [7:0]        r_sum_acc;
  logic [7:0]        r_max_acc;
  logic [7:0]        r_sum_out;
  logic [8:0]        r_max_out;

  logic              w_start_run;
  logic              w_accept;
  logic              w_last;
  logic [7:0]        w_sum_new;
  logic [7:0]        w_max_new;

`ifndef MEM_FILL_EXT_DATA_EN
  // An all-zero LFSR would lock up, so a zero seed becomes 8'h01.
  localparam logic [7:0] SEED_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
`else
  logic w_take;

  // Only one byte is ever in flight: take a new byte only while no write
  // is waiting for the memory.
  assign din_ready = (r_state == S_FILL) && !r_wr_en;
  assign w_take    = din_valid && din_ready;
`endif

  assign w_start_run = (r_state == S_IDLE) && start;
  assign w_accept    = r_wr_en && wr_if.wr_ready;
  assign w_last      = (r_addr == LAST_ADDR);
  assign w_sum_new   = r_sum_acc + r_data;
  assign w_max_new   = (r_data > r_max_acc) ? r_data : r_max_acc;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_FILL;
      S_FILL:  if (w_accept && w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write port and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_data    <= 8'h00;
      r_sum_acc <= 8'h00;
      r_max_acc <= 8'h00;
      r_sum_out <= 8'h00;
      r_max_out <= 9'h000;
`ifndef MEM_FILL_EXT_DATA_EN
      r_lfsr    <= SEED_INIT;
`endif
    end else if (w_start_run) begin
      r_addr    <= '0;
      r_sum_acc <= 8'h00;
      r_max_acc <= 8'h00;
`ifndef MEM_FILL_EXT_DATA_EN
      r_lfsr    <= SEED_INIT;
      r_data    <= SEED_INIT;
      r_wr_en   <= 1'b1;
`else
      r_wr_en   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_sum_acc <= w_sum_new;
      r_max_acc <= w_max_new;
      if (w_last) begin
        r_wr_en   <= 1'b0;
        r_sum_out <= w_sum_new;
        r_max_out <= {1'b0, w_max_new};
      end else begin
        r_addr <= r_addr + 1'b1;
`ifndef MEM_FILL_EXT_DATA_EN
        r_lfsr <= w_lfsr_next;
        r_data <= w_lfsr_next;
`else
        r_wr_en <= 1'b0;
`endif
      end
`ifdef MEM_FILL_EXT_DATA_EN
    end else if (w_take) begin
      r_data  <= din;
      r_wr_en <= 1'b1;
`endif
    end
  end

  assign busy          = (r_state == S_FILL);
  assign done          = (r_state == S_DONE);
  assign dbg_state     = r_state;
  assign sum_out       = r_sum_out;
  assign max_out       = r_max_out;
  assign wr_if.wr_en   = r_wr_en;
  assign wr_if.wr_addr = r_addr;
  assign wr_if.wr_data = r_data;

endmodule

// File: tb/tb_mem_fill_writer.sv
// tb_mem_fill_writer
//   Bench for mem_fill_writer. Three instances:
//     u_dut  DEPTH=14, SEED=A5 : randomized wr_ready / stray starts,
//                                scoreboard against a byte-list model
//     u_d4   DEPTH=4           : directed no-stall and stall runs
//     u_s0   DEPTH=2, SEED=00  : zero-seed substitution
module tb_mem_fill_writer;

  localparam int DEPTH = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic       start, busy, done;
  logic [1:0] dbg_state;
  logic [7:0] sum_out;
  logic [8:0] max_out;
  mem_fill_writer_if #(.ADDR_W(4)) wif ();

  logic       start4, busy4, done4;
  logic [1:0] dbg_state4;
  logic [7:0] sum_out4;
  logic [8:0] max_out4;
  mem_fill_writer_if #(.ADDR_W(2)) wif4 ();

  logic       start0, busy0, done0;
  logic [1:0] dbg_state0;
  logic [7:0] sum_out0;
  logic [8:0] max_out0;
  mem_fill_writer_if #(.ADDR_W(1)) wif0 ();

`ifdef MEM_FILL_EXT_DATA_EN
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, din_ready4, din_ready0;
`endif

  mem_fill_writer #(.DEPTH(DEPTH), .ADDR_W(4), .SEED(8'hA5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .dbg_state(dbg_state), .sum_out(sum_out), .max_out(max_out),
`ifdef MEM_FILL_EXT_DATA_EN
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
`endif
    .wr_if(wif.master)
  );

  mem_fill_writer #(.DEPTH(4), .ADDR_W(2), .SEED(8'hA5)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
    .dbg_state(dbg_state4), .sum_out(sum_out4), .max_out(max_out4),
`ifdef MEM_FILL_EXT_DATA_EN
    .din(din), .din_valid(din_valid), .din_ready(din_ready4),
`endif
    .wr_if(wif4.master)
  );

  mem_fill_writer #(.DEPTH(2), .ADDR_W(1), .SEED(8'h00)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .dbg_state(dbg_state0), .sum_out(sum_out0), .max_out(max_out0),
`ifdef MEM_FILL_EXT_DATA_EN
    .din(din), .din_valid(din_valid), .din_ready(din_ready0),
`endif
    .wr_if(wif0.master)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The byte sequence of a run is the seed followed by successive LFSR
  // steps; sum and max are folded over that list with plain arithmetic.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  logic [11:0] exp_q[$];   // {addr[3:0], data[7:0]}
  logic [7:0]  exp_sum;
  logic [8:0]  exp_max;

  task automatic build_expected(input logic [7:0] seed, input int depth);
    logic [7:0] v;
    int         s;
    int         m;
    v = (seed == 8'h00) ? 8'h01 : seed;
    s = 0;
    m = 0;
    exp_q.delete();
    for (int i = 0; i < depth; i++) begin
      exp_q.push_back({4'(i), v});
      s = s + int'(v);
      if (int'(v) > m) m = int'(v);
      v = lfsr_step(v);
    end
    exp_sum = 8'(s % 256);
    exp_max = 9'(m);
  endtask

  // ---------------- scoreboard monitor (u_dut) ----------------
  int wr_cnt   = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_done_excl", 32'(busy & done), 0);
      check("wr_en_only_in_fill", 32'(wif.wr_en & ~busy), 0);
      if (wif.wr_en && wif.wr_ready) begin
        check("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wif.wr_addr), 32'(e[11:8]));
          check("wr_data", 32'(wif.wr_data), 32'(e[7:0]));
        end
        wr_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_main(input int ready_pct, input bit stray_starts);
    int cycles;
    int done_iter;
    bit got_done;
    int w0;
    int d0;
    build_expected(8'hA5, DEPTH);
    w0 = wr_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got_done  = 1'b0;
    done_iter = -1;
    cycles    = 0;
    while (!got_done && cycles < 400) begin
      wif.wr_ready = ($urandom_range(99) < ready_pct);
      if (stray_starts) start = 1'($urandom_range(1));
      @(negedge clk);
      if (done) begin
        got_done  = 1'b1;
        done_iter = cycles;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    wif.wr_ready = 1'b1;
    check("done_seen", 32'(got_done), 1);
    if (ready_pct == 100) check("done_latency", 32'(done_iter), DEPTH);
    @(negedge clk);
    check("idle_after_done", 32'(dbg_state), 0);
    check("busy_after_done", 32'(busy), 0);
    check("sum_out", 32'(sum_out), 32'(exp_sum));
    check("max_out", 32'(max_out), 32'(exp_max));
    check("write_count", 32'(wr_cnt - w0), DEPTH);
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("exp_q_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic reset_mid_run();
    bit found;
    int d0;
    build_expected(8'hA5, DEPTH);
    wif.wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (wif.wr_addr == 4'd5 && wif.wr_en) found = 1'b1;
    end
    check("reached_addr5", 32'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_wr_en_async", 32'(wif.wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sum_out", 32'(sum_out), 0);
    check("rst_max_out", 32'(max_out), 0);
    check("rst_state", 32'(dbg_state), 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt - d0), 0);
    check("idle_after_rst", 32'(busy), 0);
  endtask

  task automatic directed_d4(input int stall_at, input int stall_len);
    logic [7:0] d[4];
    int         k;
    int         stalled;
    d[0] = 8'hA5; d[1] = 8'h4A; d[2] = 8'h95; d[3] = 8'h2A;
    wif4.wr_ready = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    k = 0;
    stalled = 0;
    for (int cyc = 0; cyc < 4 + stall_len; cyc++) begin
      wif4.wr_ready = !(k == stall_at && stalled < stall_len);
      @(negedge clk);
      check("d4_wr_en", 32'(wif4.wr_en), 1);
      check("d4_addr", 32'(wif4.wr_addr), 32'(k));
      check("d4_data", 32'(wif4.wr_data), 32'(d[k]));
      check("d4_done_low", 32'(done4), 0);
      @(posedge clk); #1;
      if (wif4.wr_ready) k++;
      else stalled++;
    end
    @(negedge clk);
    check("d4_done", 32'(done4), 1);
    check("d4_wr_en_off", 32'(wif4.wr_en), 0);
    check("d4_sum", 32'(sum_out4), 32'h0AE);
    check("d4_max", 32'(max_out4), 32'h0A5);
    @(negedge clk);
    check("d4_done_one_cycle", 32'(done4), 0);
    check("d4_idle", 32'(dbg_state4), 0);
  endtask

  task automatic directed_s0();
    wif0.wr_ready = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(negedge clk);
    check("s0_addr0", 32'(wif0.wr_addr), 0);
    check("s0_data0", 32'(wif0.wr_data), 32'h01);
    @(negedge clk);
    check("s0_addr1", 32'(wif0.wr_addr), 1);
    check("s0_data1", 32'(wif0.wr_data), 32'h02);
    @(negedge clk);
    check("s0_done", 32'(done0), 1);
    check("s0_sum", 32'(sum_out0), 32'h03);
    check("s0_max", 32'(max_out0), 32'h002);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    start = 1'b0; start4 = 1'b0; start0 = 1'b0;
    wif.wr_ready = 1'b1; wif4.wr_ready = 1'b1; wif0.wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_wr_en", 32'(wif.wr_en), 0);
    check("reset_wr_addr", 32'(wif.wr_addr), 0);
    check("reset_wr_data", 32'(wif.wr_data), 0);
    check("reset_sum", 32'(sum_out), 0);
    check("reset_max", 32'(max_out), 0);
    check("reset_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_main(100, 1'b0);
    run_main(100, 1'b1);
    run_main(100, 1'b0);
    for (int r = 0; r < 4; r++) run_main(int'($urandom_range(90, 30)), 1'b1);
    reset_mid_run();
    run_main(100, 1'b0);

    directed_d4(-1, 0);
    directed_d4(2, 3);
    directed_s0();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fill_writer.md
Name: mem_fill_writer

Overview:
- Sequential write-side companion to the team's memory reduction logic: on `start`, writes DEPTH pseudo-random bytes to addresses 0..DEPTH-1 of an external memory write port.
- Uses a valid/ready handshake toward the memory.
- Accumulates a modulo-256 sum and the largest written value, so the reader's results can be cross-checked against them.
- Sits between the test/control logic and the memory array.

Parameters:
- DEPTH, 14, number of entries written per run (2..2**ADDR_W).
- ADDR_W, 4, width of the write address.
- SEED, 8'hA5, LFSR value loaded at each start; 8'h00 is replaced by 8'h01.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a fill run; sampled only in IDLE
- busy  output  1  high in FILL state
- done  output  1  one-cycle pulse after the last write is accepted
- wr_en  output  1  write request valid
- wr_ready  input  1  memory accepts the write this cycle
- wr_addr  output  ADDR_W  write address
- wr_data  output  8  write data
- sum_out  output  8  modulo-256 sum of all bytes written in the last run
- max_out  output  9  largest byte written, zero-extended to 9 bits

Behaviour:
- Clock/reset (decided): one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: state=IDLE; busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, sum_out=0, max_out=0; LFSR=SEED.
- States: IDLE, FILL, DONE.
- IDLE -> FILL on start=1.
  - Load LFSR=SEED, wr_addr=0, wr_data=SEED, wr_en=1, sum acc=0, max acc=0.
  - First wr_en is visible the cycle after start.
- FILL: a write is accepted when wr_en && wr_ready at a rising edge.
  - On accept: sum acc += wr_data (8-bit wrap); max acc = max(max acc, wr_data).
  - If wr_addr != DEPTH-1: wr_addr+1, LFSR advances, wr_data = new LFSR, wr_en stays 1.
  - If wr_addr == DEPTH-1: wr_en=0, transfer accumulators to sum_out/max_out, go to DONE.
  - When wr_ready=0: wr_en, wr_addr, wr_data and LFSR hold unchanged; no accumulation.
- LFSR step: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- DONE: done=1 for exactly one cycle, then IDLE.
- sum_out/max_out:
  - Hold from DONE until the next run completes.
  - Not cleared by start; they change only at completion or reset.
- start: ignored in FILL and DONE; no queuing.
- Throughput: with wr_ready tied high, start at cycle 0 gives writes in cycles 1..DEPTH, done at cycle DEPTH+1, and the earliest restart at cycle DEPTH+2.
- Reset mid-run:
  - wr_en drops immediately (asynchronous).
  - The partial run is discarded; sum_out/max_out go to 0.
  - No done pulse.
- busy=1 exactly while in FILL; busy and done are never high together.

Optional Feature:
- MEM_FILL_EXT_DATA_EN.
- Defined:
  - Adds ports `din` (input 8), `din_valid` (input 1), `din_ready` (output 1).
  - wr_data comes from din instead of the LFSR.
  - The block takes a byte only when din_valid && din_ready; din_ready=1 in FILL while no write is pending.
  - wr_en asserts the cycle after a byte is taken.
  - Sum/max accumulate on the memory accept as before.
  - The LFSR is not instantiated.
- Undefined: LFSR data source as specified above; the din ports do not exist.

Test Plan:
- DEPTH=4, wr_ready=1, pulse start -> addr 0..3 data A5,4A,95,2A on consecutive cycles; done pulse next cycle; sum_out=8'hAE; max_out=9'h0A5.
- DEPTH=4, hold wr_ready=0 for 3 cycles while wr_addr=2 -> wr_addr=2 and wr_data=95 stable across the stall; final sum_out=8'hAE; done delayed by 3 cycles.
- Default DEPTH=14, wr_ready=1, start, then start again during FILL -> second start ignored; exactly 14 writes; one done pulse; then back-to-back run repeats identical data/sum.
- Assert rst_n=0 while wr_addr=5 -> wr_en=0 asynchronously; busy=0; sum_out=0; no done; a fresh start rewrites from addr 0 with data A5.
- SEED=8'h00, DEPTH=2 -> data 01 then 02; sum_out=8'h03; max_out=9'h002.
- MEM_FILL_EXT_DATA_EN, DEPTH=3, din 0xFF,0xFF,0x10 -> sum_out=8'h0E; max_out=9'h0FF; din_ready low while a write is pending.
